ook_dds: RTL and testbench

- On-off-keyed direct digital synthesizer; the TinyTapeout top-level user block for the OOK transmitter.
- A 24-bit phase accumulator advances by a programmable frequency tuning word (FTW) every enabled clock.
- The top 8 phase bits address a sine (or square) waveform, producing an 8-bit unsigned sample on uo_out.
- An external key input gates the carrier: key off drives uo_out to midscale 0x80.

---
 rtl/ook_dds.sv | 118 +++++++++++
 tb/tb_ook_dds.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ook_dds.sv
// rtl/ook_dds.sv - on-off-keyed DDS: 24-bit phase accumulator, sine/square LUT, keyed to midscale 0x80.
// Optional OOK_ZC_SYNC_EN: key changes take effect only when the accumulator wraps (phase zero).
module ook_dds #(
    parameter logic [23:0] FTW_RESET = 24'h000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic        key_m, key_s;
    logic        wr_m, wr_s, wr_d;
    logic [23:0] acc, ftw;
    logic [1:0]  ctrl;
    logic [7:0]  sample;
    logic [24:0] acc_sum;
    logic        wr_pulse;
    logic        keyon;
    logic [7:0]  phase;
    logic [6:0]  qidx, qmag;
    logic [7:0]  wave;
    logic        unused_bits;

    // round(127*sin(2*pi*i/256)) for the first quadrant; index 64 falls to the default peak
    function automatic logic [6:0] quarter_sine(input logic [6:0] idx);
        logic [6:0] q;
        case (idx)
            7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
            7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
            7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
            7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
            7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
            7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
            7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
            7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
            7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
            7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
            7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
            7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
            7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
            7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
            default: q = 7'd127;
        endcase
        return q;
    endfunction

    assign acc_sum     = {1'b0, acc} + {1'b0, ftw};
    assign wr_pulse    = wr_s & ~wr_d;
    assign unused_bits = ^{ui_in[7:4], acc_sum[24]};

    // Second quadrant mirrors the first, second half negates around midscale
    always_comb begin
        phase = acc[23:16];
        qidx  = phase[6] ? (7'd64 - {1'b0, phase[5:0]}) : {1'b0, phase[5:0]};
        qmag  = quarter_sine(qidx);
        if (ctrl[0])
            wave = phase[7] ? 8'h01 : 8'hFF;
        else
            wave = phase[7] ? (8'd128 - {1'b0, qmag}) : (8'd128 + {1'b0, qmag});
    end

`ifdef OOK_ZC_SYNC_EN
    logic keyon_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            keyon_q <= 1'b0;
        else if (ena && (acc_sum[24] || ftw == 24'd0))
            keyon_q <= key_s ^ ctrl[1];
    end

    assign keyon = keyon_q;
`else
    assign keyon = key_s ^ ctrl[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_m  <= 1'b0;
            key_s  <= 1'b0;
            wr_m   <= 1'b0;
            wr_s   <= 1'b0;
            wr_d   <= 1'b0;
            acc    <= 24'd0;
            ftw    <= FTW_RESET;
            ctrl   <= 2'b00;
            sample <= 8'h80;
        end else if (ena) begin
            key_m  <= ui_in[0];
            key_s  <= key_m;
            wr_m   <= ui_in[1];
            wr_s   <= wr_m;
            wr_d   <= wr_s;
            acc    <= acc_sum[23:0];
            sample <= keyon ? wave : 8'h80;
            if (wr_pulse) begin
                case (ui_in[3:2])
                    2'd0: ftw[7:0]   <= uio_in;
                    2'd1: ftw[15:8]  <= uio_in;
                    2'd2: ftw[23:16] <= uio_in;
                    2'd3: ctrl       <= uio_in[1:0];
                endcase
            end
        end
    end

    assign uo_out  = sample;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_ook_dds.sv
// tb/tb_ook_dds.sv - self-checking bench for ook_dds: directed tables, landmark sequences, randomized scoreboard.
module tb_ook_dds;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    ook_dds dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] wave_ref(input int p, input bit sq);
        real v;
        int  r;
        if (sq) return (p < 128) ? 8'hFF : 8'h01;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
        r = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
        return 8'(128 + r);
    endfunction

    // Reference model: per enabled edge, using histories of sampled inputs
    int         acc_m, ftw_m, ctrl_m;
    bit         keyon_m;
    bit         key_q[$];
    bit         wr_q[$];
    logic [7:0] exp_uo = 8'h80;
    bit         mvalid = 1'b0;

    always @(posedge clk) begin : model
        bit ks, keyon, do_wr;
        if (!rst_n) begin
            acc_m = 0; ftw_m = 0; ctrl_m = 0; keyon_m = 1'b0;
            key_q = {1'b0, 1'b0, 1'b0};
            wr_q  = {1'b0, 1'b0, 1'b0};
            exp_uo = 8'h80;
            mvalid = 1'b1;
        end else if (ena && mvalid) begin
            ks = key_q[1];
`ifdef OOK_ZC_SYNC_EN
            keyon = keyon_m;
            if (acc_m + ftw_m >= (1 << 24) || ftw_m == 0) keyon_m = ks ^ ctrl_m[1];
`else
            keyon = ks ^ ctrl_m[1];
`endif
            exp_uo = keyon ? wave_ref((acc_m >> 16) & 255, ctrl_m[0]) : 8'h80;
            do_wr  = wr_q[1] && !wr_q[2];
            acc_m  = (acc_m + ftw_m) % (1 << 24);
            if (do_wr) begin
                case (ui_in[3:2])
                    2'd0: ftw_m = (ftw_m & 'hFFFF00) | int'(uio_in);
                    2'd1: ftw_m = (ftw_m & 'hFF00FF) | (int'(uio_in) << 8);
                    2'd2: ftw_m = (ftw_m & 'h00FFFF) | (int'(uio_in) << 16);
                    2'd3: ctrl_m = int'(uio_in) & 3;
                endcase
            end
            key_q.push_front(ui_in[0]);
            void'(key_q.pop_back());
            wr_q.push_front(ui_in[1]);
            void'(wr_q.pop_back());
        end
        #1;
        if (mvalid) chk("uo_out_model", uo_out, exp_uo);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        ui_in[3:2] = a;
        uio_in     = d;
        ui_in[1]   = 1'b1;
        cyc(4);
        ui_in[1]   = 1'b0;
        cyc(4);
    endtask

    typedef struct {
        logic [7:0]  ftw_hi;
        logic [1:0]  ctrl;
        logic        key;
        logic [31:0] pat;
    } qvec_t;

    qvec_t      qt[6];
    logic [7:0] s[520];
    logic [7:0] hold;
    int         i1, wr_hi, wr_lo;
    bit         ok, ok_any;

    initial begin
        qt[0] = '{8'h40, 2'b00, 1'b1, 32'h80FF8001};
        qt[1] = '{8'h40, 2'b01, 1'b1, 32'hFFFF0101};
        qt[2] = '{8'h80, 2'b01, 1'b1, 32'hFF01FF01};
        qt[3] = '{8'h40, 2'b10, 1'b0, 32'h80FF8001};
        qt[4] = '{8'hC0, 2'b00, 1'b1, 32'h800180FF};
        qt[5] = '{8'h40, 2'b10, 1'b1, 32'h80808080};

        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h01; uio_in = 8'h00;
        cyc(2);
        chk("reset_uo_out", uo_out, 8'h80);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b1;
        cyc(5);
        chk("key_on_ftw0", uo_out, 8'h80);

        // Sine sweep at one phase step per clock
        ui_in[0] = 1'b0;
        wr_reg(2'd0, 8'h00);
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd2, 8'h01);
        ui_in[0] = 1'b1;
        cyc(3);
        for (int i = 0; i < 520; i++) begin
            s[i] = uo_out;
            cyc(1);
        end
        i1 = -1;
        for (int i = 1; i <= 256; i++)
            if (i1 < 0 && s[i] == 8'h83 && s[i+1] == 8'h86) i1 = i;
        chk("sweep_83_86_found", (i1 >= 0) ? 1 : 0, 1);
        if (i1 >= 0) begin
            chk("sweep_n0", s[i1-1], 8'h80);
            chk("sweep_n64", s[i1+63], 8'hFF);
            chk("sweep_n128", s[i1+127], 8'h80);
            chk("sweep_n192", s[i1+191], 8'h01);
            chk("sweep_n256", s[i1+255], 8'h80);
        end

        // Key off: midscale on the third edge after the change
        ui_in[0] = 1'b0;
        cyc(3);
        chk("key_off_lat3", uo_out, 8'h80);
        ui_in[0] = 1'b1;
        cyc(8);
        wr_reg(2'd3, 8'h02);
        cyc(4);
        chk("key_inverted", uo_out, 8'h80);
        wr_reg(2'd3, 8'h00);
        cyc(5);

        hold = exp_uo;
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("ena_hold", uo_out, hold);
        end
        ena = 1'b1;
        cyc(20);

        // Quarter-step and mode table; each entry starts from phase zero
        foreach (qt[k]) begin
            rst_n = 1'b0;
            cyc(2);
            rst_n = 1'b1;
            ui_in[0] = qt[k].key;
            wr_reg(2'd3, {6'd0, qt[k].ctrl});
            wr_reg(2'd2, qt[k].ftw_hi);
            cyc(4);
            for (int j = 0; j < 8; j++) begin
                s[j] = uo_out;
                cyc(1);
            end
            ok_any = 1'b0;
            for (int r = 0; r < 4; r++) begin
                ok = 1'b1;
                for (int j = 0; j < 8; j++)
                    if (s[j] != qt[k].pat[8*(3-((j+r)%4)) +: 8]) ok = 1'b0;
                if (ok) ok_any = 1'b1;
            end
            if (!ok_any)
                $display("FAIL qtab[%0d]: got %02h %02h %02h %02h expected rotation of %08h",
                         k, s[0], s[1], s[2], s[3], qt[k].pat);
            n_cmp++;
            if (!ok_any) n_err++;
        end

        // Randomized traffic checked by the model every clock
        wr_hi = 0; wr_lo = 0;
        for (int it = 0; it < 4000; it++) begin
            ena = ($urandom_range(0, 7) != 0);
            rst_n = ($urandom_range(0, 799) != 0);
            ui_in[7:4] = 4'($urandom);
            if ($urandom_range(0, 15) == 0) ui_in[0] = ~ui_in[0];
            if (wr_hi > 0) begin
                wr_hi--;
                if (wr_hi == 0) ui_in[1] = 1'b0;
            end else if (wr_lo > 0) begin
                wr_lo--;
            end else if ($urandom_range(0, 29) == 0) begin
                ui_in[3:2] = 2'($urandom);
                uio_in     = 8'($urandom);
                ui_in[1]   = 1'b1;
                wr_hi      = $urandom_range(1, 4);
                wr_lo      = 6;
            end
            cyc(1);
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
